// File: rtl/id_ex_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_ex_hazard_ctrl                                          |
// | Description : Hazard feedback controller sitting between the decode      |
// |               stage and the ID/EX pipeline register. Looks at the        |
// |               instruction in EX and the instruction in ID and produces   |
// |               the PC hold, IF/ID hold/flush and ID/EX bubble controls.   |
// |               Handles:                                                   |
// |                 - load-use hazards (multi-cycle stall)                   |
// |                 - taken branches / jumps resolved in EX (multi-cycle     |
// |                   flush)                                                 |
// |               and keeps saturating counters of stall and flush cycles.   |
// | Parameters  : REG_W             register-specifier width                 |
// |               LOAD_STALL_CYCLES stall cycles per load-use (1..7)         |
// |               FLUSH_CYCLES      flush cycles per redirect (1..7)         |
// |               CNT_W             performance counter width                |
// | Ports       : clk, rst_n (synchronous, active low)                       |
// |               ID_rs/ID_rt/ID_uses_rs/ID_uses_rt  decode-side operands    |
// |               EX_dest/EX_RegWrite/EX_mem_read    execute-side producer   |
// |               EX_redirect                        redirect taken in EX    |
// |               pc_write/if_id_write               1 = stage may advance   |
// |               if_id_flush                        IF/ID loads a NOP       |
// |               id_ex_bubble                       ID/EX loads zero ctrl   |
// |               stall_cnt/flush_cnt                saturating counters     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module id_ex_hazard_ctrl #(
  parameter int REG_W             = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic [REG_W-1:0] EX_dest,
  input  logic             EX_RegWrite,
  input  logic             EX_mem_read,
  input  logic             EX_redirect,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Remaining-cycle reload values. The first cycle of a stall or flush is
  // spent in RUN (or in the state that saw the redirect), so the dedicated
  // state only has to cover the cycles after that one.
  localparam logic [2:0]       c_stall_rem   = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0]       c_flush_rem   = 3'(FLUSH_CYCLES - 1);
  localparam bit               c_multi_stall = (LOAD_STALL_CYCLES > 1);
  localparam bit               c_multi_flush = (FLUSH_CYCLES > 1);
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_rem;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  state_t           w_next_state;
  logic [2:0]       w_next_rem;
  logic             w_load_use;
  logic             w_rs_hit;
  logic             w_rt_hit;
  logic             w_pc_write;
  logic             w_if_id_write;
  logic             w_if_id_flush;
  logic             w_id_ex_bubble;

  // ---------------------------------------------------------------------------
  // Load-use detection. r0 is hardwired to zero, so a load targeting it can
  // never produce a value the ID instruction has to wait for.
  // ---------------------------------------------------------------------------
  assign w_rs_hit   = ID_uses_rs && (ID_rs == EX_dest);
  assign w_rt_hit   = ID_uses_rt && (ID_rt == EX_dest);
  assign w_load_use = EX_mem_read && EX_RegWrite && (EX_dest != '0) &&
                      (w_rs_hit || w_rt_hit);

  // ---------------------------------------------------------------------------
  // Output / next-state decode. Outputs depend on the registered state and
  // the current inputs so a hazard is acted on in the cycle it appears.
  // Priority: reset, then redirect, then the state-specific behaviour.
  // ---------------------------------------------------------------------------
  always_comb begin
    // Free-running pattern by default.
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_bubble = 1'b0;
    w_next_state   = r_state;
    w_next_rem     = r_rem;

    if (!rst_n) begin
      // Hold the front end and squash everything while in reset.
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_if_id_flush  = 1'b1;
      w_id_ex_bubble = 1'b1;
      w_next_state   = ST_RUN;
      w_next_rem     = 3'd0;
    end else if (EX_redirect) begin
      // A redirect discards the wrong-path instructions in IF/ID and ID, so
      // it overrides any pending stall. In FLUSH it restarts the count.
      w_pc_write     = 1'b1;
      w_if_id_write  = 1'b1;
      w_if_id_flush  = 1'b1;
      w_id_ex_bubble = 1'b1;
      if (c_multi_flush) begin
        w_next_state = ST_FLUSH;
        w_next_rem   = c_flush_rem;
      end else begin
        w_next_state = ST_RUN;
        w_next_rem   = 3'd0;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_load_use) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_if_id_flush  = 1'b0;
            w_id_ex_bubble = 1'b1;
            if (c_multi_stall) begin
              w_next_state = ST_STALL;
              w_next_rem   = c_stall_rem;
            end
          end
        end

        ST_STALL: begin
          // The stall length is fixed at entry; a fresh load_use seen here
          // does not extend it.
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_if_id_flush  = 1'b0;
          w_id_ex_bubble = 1'b1;
          if (r_rem <= 3'd1) begin
            w_next_state = ST_RUN;
            w_next_rem   = 3'd0;
          end else begin
            w_next_rem   = r_rem - 3'd1;
          end
        end

        ST_FLUSH: begin
          w_pc_write     = 1'b1;
          w_if_id_write  = 1'b1;
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b1;
          if (r_rem <= 3'd1) begin
            w_next_state = ST_RUN;
            w_next_rem   = 3'd0;
          end else begin
            w_next_rem   = r_rem - 3'd1;
          end
        end

        default: begin
          // Unused encoding: recover to RUN.
          w_next_state = ST_RUN;
          w_next_rem   = 3'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_rem   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_rem   <= w_next_rem;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters. They stop at all-ones so a long run
  // reads as "at least this many" rather than wrapping to a small number.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_write && (r_stall_cnt != c_cnt_max)) begin
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
      end
      if (w_if_id_flush && (r_flush_cnt != c_cnt_max)) begin
        r_flush_cnt <= r_flush_cnt + c_cnt_one;
      end
    end
  end

  assign pc_write     = w_pc_write;
  assign if_id_write  = w_if_id_write;
  assign if_id_flush  = w_if_id_flush;
  assign id_ex_bubble = w_id_ex_bubble;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_id_ex_hazard_ctrl                                       |
// | Description : Self-checking bench for id_ex_hazard_ctrl. Two instances:  |
// |               dut_a (LOAD_STALL_CYCLES=3, FLUSH_CYCLES=2, CNT_W=16) and  |
// |               dut_b (LOAD_STALL_CYCLES=1, FLUSH_CYCLES=1, CNT_W=4),      |
// |               sharing one stimulus stream. A cycle-level reference       |
// |               model tracks pending stall/flush cycles and counters.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_id_ex_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       ID_uses_rs;
  logic       ID_uses_rt;
  logic [4:0] EX_dest;
  logic       EX_RegWrite;
  logic       EX_mem_read;
  logic       EX_redirect;

  logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_bubble;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  id_ex_hazard_ctrl #(
    .REG_W(5), .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .EX_dest(EX_dest), .EX_RegWrite(EX_RegWrite), .EX_mem_read(EX_mem_read),
    .EX_redirect(EX_redirect),
    .pc_write(a_pc_write), .if_id_write(a_if_id_write), .if_id_flush(a_if_id_flush),
    .id_ex_bubble(a_id_ex_bubble), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  id_ex_hazard_ctrl #(
    .REG_W(5), .LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .EX_dest(EX_dest), .EX_RegWrite(EX_RegWrite), .EX_mem_read(EX_mem_read),
    .EX_redirect(EX_redirect),
    .pc_write(b_pc_write), .if_id_write(b_if_id_write), .if_id_flush(b_if_id_flush),
    .id_ex_bubble(b_id_ex_bubble), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt,
                            input logic [4:0] dest, input logic rw,
                            input logic mr, input logic redir);
    ID_rs = rs; ID_rt = rt; ID_uses_rs = urs; ID_uses_rt = urt;
    EX_dest = dest; EX_RegWrite = rw; EX_mem_read = mr; EX_redirect = redir;
  endtask

  task automatic idle();
    set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: per instance, the number of stall / flush cycles still
  // owed after the current one, plus unbounded counters clipped to the max.
  // Output bits are {pc_write, if_id_write, if_id_flush, id_ex_bubble}.
  // ---------------------------------------------------------------------------
  int m_stall_left [2] = '{0, 0};
  int m_flush_left [2] = '{0, 0};
  int m_scnt       [2] = '{0, 0};
  int m_fcnt       [2] = '{0, 0};
  int p_load       [2] = '{3, 1};
  int p_flush      [2] = '{2, 1};
  int p_max        [2] = '{65535, 15};

  function automatic bit ref_load_use();
    if (!(EX_mem_read && EX_RegWrite) || EX_dest == 5'd0) return 1'b0;
    return (ID_uses_rs && ID_rs == EX_dest) || (ID_uses_rt && ID_rt == EX_dest);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0] act;
        logic [3:0] expv;
        int acs;
        int acf;
        if (d == 0) begin
          act = {a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble};
          acs = int'(a_stall_cnt);
          acf = int'(a_flush_cnt);
        end else begin
          act = {b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_bubble};
          acs = int'(b_stall_cnt);
          acf = int'(b_flush_cnt);
        end
        check($sformatf("model_dut%0d_stall_cnt", d), acs, m_scnt[d]);
        check($sformatf("model_dut%0d_flush_cnt", d), acf, m_fcnt[d]);

        if (!rst_n) begin
          expv = 4'b0011;
        end else if (EX_redirect) begin
          expv = 4'b1111;
          m_flush_left[d] = p_flush[d] - 1;
          m_stall_left[d] = 0;
        end else if (m_flush_left[d] > 0) begin
          expv = 4'b1111;
          m_flush_left[d]--;
        end else if (m_stall_left[d] > 0) begin
          expv = 4'b0001;
          m_stall_left[d]--;
        end else if (ref_load_use()) begin
          expv = 4'b0001;
          m_stall_left[d] = p_load[d] - 1;
        end else begin
          expv = 4'b1100;
        end
        check($sformatf("model_dut%0d_outputs", d), int'(act), int'(expv));

        if (!rst_n) begin
          m_scnt[d] = 0;
          m_fcnt[d] = 0;
          m_stall_left[d] = 0;
          m_flush_left[d] = 0;
        end else begin
          if (!expv[3] && m_scnt[d] < p_max[d]) m_scnt[d]++;
          if (expv[1] && m_fcnt[d] < p_max[d]) m_fcnt[d]++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Single-cycle decode table, applied to dut_b (1-cycle stall and flush, so
  // it is always back in RUN at the start of each vector).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       redir;
    logic [3:0] exp_out;
  } vec_t;

  vec_t vecs [11];

  initial begin
    //          rs     rt    urs   urt  dest   rw    mr   redir  exp
    vecs[0]  = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 4'b1100};
    vecs[1]  = '{5'd5,  5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 4'b0001};
    vecs[2]  = '{5'd1,  5'd7, 1'b1, 1'b1, 5'd7,  1'b1, 1'b1, 1'b0, 4'b0001};
    vecs[3]  = '{5'd0,  5'd0, 1'b1, 1'b1, 5'd0,  1'b1, 1'b1, 1'b0, 4'b1100};
    vecs[4]  = '{5'd5,  5'd0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 4'b1100};
    vecs[5]  = '{5'd5,  5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 4'b1100};
    vecs[6]  = '{5'd5,  5'd0, 1'b1, 1'b0, 5'd5,  1'b0, 1'b1, 1'b0, 4'b1100};
    vecs[7]  = '{5'd3,  5'd5, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 4'b1100};
    vecs[8]  = '{5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 4'b1111};
    vecs[9]  = '{5'd5,  5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b1, 4'b1111};
    vecs[10] = '{5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0, 4'b0001};

    rst_n = 1'b0;
    idle();
    step();
    step();
    mon_en = 1'b1;
    check("reset_pc_write", int'(a_pc_write), 0);
    check("reset_if_id_flush", int'(a_if_id_flush), 1);
    check("reset_stall_cnt", int'(a_stall_cnt), 0);
    rst_n = 1'b1;
    #1;
    check("release_pc_write", int'(a_pc_write), 1);

    // Table vectors
    for (int i = 0; i < 11; i++) begin
      set_inputs(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
                 vecs[i].dest, vecs[i].rw, vecs[i].mr, vecs[i].redir);
      #1;
      check($sformatf("vec%0d_outputs", i),
            int'({b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_bubble}),
            int'(vecs[i].exp_out));
      step();
    end

    // Clean restart for the hand sequences.
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("restart_a_stall_cnt", int'(a_stall_cnt), 0);
    check("restart_b_flush_cnt", int'(b_flush_cnt), 0);

    // Load-use on r5, single-cycle stall (dut_b)
    set_inputs(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    check("lu_b_pc_write", int'(b_pc_write), 0);
    check("lu_b_if_id_write", int'(b_if_id_write), 0);
    check("lu_b_bubble", int'(b_id_ex_bubble), 1);
    step();
    idle();
    #1;
    check("lu_b_after_pc_write", int'(b_pc_write), 1);
    check("lu_b_stall_cnt", int'(b_stall_cnt), 1);
    // dut_a is on its 2nd of 3 stall cycles with no hazard on the inputs.
    check("lu_a_stall2_pc_write", int'(a_pc_write), 0);
    repeat (4) step();
    check("lu_a_stall_cnt", int'(a_stall_cnt), 3);

    // Redirect, 2-cycle flush (dut_a)
    begin
      int fa;
      fa = int'(a_flush_cnt);
      EX_redirect = 1'b1;
      #1;
      check("redir_a_flush_c1", int'(a_if_id_flush), 1);
      step();
      EX_redirect = 1'b0;
      #1;
      check("redir_a_flush_c2", int'(a_if_id_flush), 1);
      check("redir_a_bubble_c2", int'(a_id_ex_bubble), 1);
      step();
      check("redir_a_flush_c3", int'(a_if_id_flush), 0);
      check("redir_a_flush_cnt", int'(a_flush_cnt), fa + 2);
    end

    // Redirect and load_use together: redirect wins
    begin
      int sa;
      sa = int'(a_stall_cnt);
      set_inputs(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
      #1;
      check("both_a_pc_write", int'(a_pc_write), 1);
      check("both_a_flush", int'(a_if_id_flush), 1);
      step();
      idle();
      check("both_a_stall_cnt", int'(a_stall_cnt), sa);
      repeat (3) step();
    end

    // Reset in the middle of a 3-cycle stall (dut_a)
    set_inputs(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    #1;
    check("rst_mid_a_stall2", int'(a_pc_write), 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_a_outputs",
          int'({a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble}), 3);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst_rel_a_outputs",
          int'({a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble}), 12);
    check("rst_rel_a_stall_cnt", int'(a_stall_cnt), 0);
    check("rst_rel_a_flush_cnt", int'(a_flush_cnt), 0);

    // 20 back-to-back load-use cycles saturate the 4-bit counter (dut_b)
    set_inputs(5'd9, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
    repeat (20) step();
    check("sat_b_stall_cnt", int'(b_stall_cnt), 15);
    repeat (3) step();
    check("sat_b_stall_cnt_hold", int'(b_stall_cnt), 15);
    idle();
    repeat (4) step();

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst_n       = ($urandom_range(0, 63) != 0);
      ID_rs       = 5'($urandom_range(0, 3));
      ID_rt       = 5'($urandom_range(0, 3));
      ID_uses_rs  = 1'($urandom_range(0, 1));
      ID_uses_rt  = 1'($urandom_range(0, 1));
      EX_dest     = 5'($urandom_range(0, 3));
      EX_RegWrite = ($urandom_range(0, 3) != 0);
      EX_mem_read = ($urandom_range(0, 2) == 0);
      EX_redirect = ($urandom_range(0, 9) == 0);
      step();
    end
    rst_n = 1'b1;
    idle();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
